// File: rtl/rubiks_pkg.sv
// Shared constants for the Rubik's robot serial receive path: FSM state codes,
// special byte values and default packing geometry.
package rubiks_pkg;

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] RECEBE = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;

  localparam logic [7:0] BYTE_SINCRONISMO = 8'hFF;
  localparam logic [7:0] BYTE_NULO        = 8'h00;

  localparam int unsigned WORD_BYTES_PADRAO  = 2;
  localparam int unsigned DEPTH_PADRAO       = 8;
  localparam int unsigned FRAME_WORDS_PADRAO = 16;

endpackage

// File: rtl/fifo_sincrona.sv
// Synchronous show-ahead FIFO. The head word is always visible on dado_saida;
// once the FIFO drains, the last head value is held instead of stale memory.
// A write while full is accepted only if a read happens in the same cycle.
module fifo_sincrona #(
  parameter int unsigned LARGURA      = 16,
  parameter int unsigned PROFUNDIDADE = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            escrever,
  input  logic [LARGURA-1:0]              dado_entrada,
  input  logic                            ler,
  output logic [LARGURA-1:0]              dado_saida,
  output logic                            cheio,
  output logic                            vazio,
  output logic [$clog2(PROFUNDIDADE):0]   quantidade
);

  localparam int unsigned PW = $clog2(PROFUNDIDADE);

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic [PW-1:0]      r_ptr_esc;
  logic [PW-1:0]      r_ptr_lei;
  logic [PW:0]        r_quant;
  logic [LARGURA-1:0] r_ultima;

  logic w_esc;
  logic w_lei;

  assign vazio      = (r_quant == '0);
  assign cheio      = (r_quant == (PW+1)'(PROFUNDIDADE));
  assign w_lei      = ler && !vazio;
  assign w_esc      = escrever && (!cheio || w_lei);
  assign quantidade = r_quant;
  assign dado_saida = vazio ? r_ultima : r_mem[r_ptr_lei];

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (w_esc) begin
      r_mem[r_ptr_esc] <= dado_entrada;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr_esc <= '0;
      r_ptr_lei <= '0;
      r_quant   <= '0;
    end else begin
      if (w_esc) r_ptr_esc <= r_ptr_esc + PW'(1);
      if (w_lei) r_ptr_lei <= r_ptr_lei + PW'(1);
      case ({w_esc, w_lei})
        2'b10:   r_quant <= r_quant + (PW+1)'(1);
        2'b01:   r_quant <= r_quant - (PW+1)'(1);
        default: r_quant <= r_quant;
      endcase
    end
  end

  // Remember each popped head so the output holds it when the FIFO runs empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ultima <= '0;
    end else if (w_lei) begin
      r_ultima <= r_mem[r_ptr_lei];
    end
  end

endmodule

// File: rtl/rx_pacote_serial.sv
// Packs bytes from the 8N1 receiver into WORD_BYTES-wide words (first byte in
// the MSB) and queues them for the control unit. Frames are either a fixed
// number of words (modo=0) or a list ended by an all-zero word (modo=1).
// Optional macro RX_TIMEOUT_EN adds an inter-byte timeout that discards a
// stalled partial word.
module rx_pacote_serial
  import rubiks_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = WORD_BYTES_PADRAO,
  parameter int unsigned DEPTH          = DEPTH_PADRAO,
  parameter int unsigned FRAME_WORDS    = FRAME_WORDS_PADRAO,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iniciar,
  input  logic                        modo,
  input  logic                        rx_pronto,
  input  logic [7:0]                  rx_dados,
  input  logic                        ler,
  output logic [8*WORD_BYTES-1:0]     palavra,
  output logic                        palavra_valida,
  output logic                        cheio,
  output logic [$clog2(DEPTH):0]      quantidade,
  output logic [15:0]                 palavras_recebidas,
  output logic                        fim_quadro,
  output logic                        erro_overflow,
  output logic [1:0]                  db_estado
);

  localparam int unsigned LW = 8 * WORD_BYTES;
  localparam int unsigned IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [1:0]    r_estado;
  logic          r_modo;
  logic [IW-1:0] r_indice;
  logic [LW-1:0] r_parcial;
  logic [15:0]   r_contagem;
  logic          r_fim;
  logic          r_overflow;

  logic          w_aceita;
  logic [LW-1:0] w_novo;
  logic          w_completa;
  logic          w_terminador;
  logic          w_push;
  logic [15:0]   w_contagem_prox;
  logic          w_fecha_quadro;
  logic          w_fifo_cheio;
  logic          w_fifo_vazio;
  logic          w_estouro;

  assign w_aceita        = (r_estado == RECEBE) && rx_pronto && !iniciar;
  assign w_novo          = (r_parcial << 8) | LW'(rx_dados);
  assign w_completa      = w_aceita && (r_indice == IW'(WORD_BYTES - 1));
  assign w_terminador    = r_modo && (w_novo == {WORD_BYTES{BYTE_NULO}});
  assign w_push          = w_completa && !w_terminador;
  assign w_contagem_prox = (r_contagem == 16'hFFFF) ? r_contagem : r_contagem + 16'd1;
  assign w_fecha_quadro  = w_completa &&
                           (w_terminador || (!r_modo && ({16'd0, w_contagem_prox} == FRAME_WORDS)));

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timer;

  assign w_estouro = (r_estado == RECEBE) && (r_indice != '0) && (r_timer == TW'(TIMEOUT_CYCLES));

  // Inter-byte timer: counts only while a partial word is pending.
  always_ff @(posedge clock) begin
    if (reset || iniciar || w_aceita || w_estouro ||
        (r_estado != RECEBE) || (r_indice == '0)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  // No timer in this build; the parameter remains part of the interface.
  assign w_estouro = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Frame FSM, byte packing, word counter and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_modo     <= 1'b0;
      r_indice   <= '0;
      r_parcial  <= '0;
      r_contagem <= '0;
      r_fim      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (iniciar) begin
      r_estado   <= RECEBE;
      r_modo     <= modo;
      r_indice   <= '0;
      r_parcial  <= '0;
      r_contagem <= '0;
      r_fim      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_fim <= w_fecha_quadro;
      if (w_aceita) begin
        r_indice  <= w_completa ? '0 : r_indice + IW'(1);
        r_parcial <= w_completa ? '0 : w_novo;
      end else if (w_estouro) begin
        r_indice  <= '0;
        r_parcial <= '0;
      end
      // A word dropped on overflow still counts toward the frame.
      if (w_push) begin
        r_contagem <= w_contagem_prox;
      end
      if (w_push && w_fifo_cheio && !ler) begin
        r_overflow <= 1'b1;
      end
      if (w_fecha_quadro) begin
        r_estado <= FIM;
      end
    end
  end

  fifo_sincrona #(
    .LARGURA      (LW),
    .PROFUNDIDADE (DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .escrever     (w_push),
    .dado_entrada (w_novo),
    .ler          (ler),
    .dado_saida   (palavra),
    .cheio        (w_fifo_cheio),
    .vazio        (w_fifo_vazio),
    .quantidade   (quantidade)
  );

  assign palavra_valida     = !w_fifo_vazio;
  assign cheio              = w_fifo_cheio;
  assign palavras_recebidas = r_contagem;
  assign fim_quadro         = r_fim;
  assign erro_overflow      = r_overflow;
  assign db_estado          = r_estado;

endmodule

// File: tb/tb_rx_pacote_serial.sv
// Bench for rx_pacote_serial: four instances with different geometries share a
// clock and reset; each scenario drives one instance and checks it against a
// table of expected words and a scoreboard queue.
module tb_rx_pacote_serial;

  logic clock;
  logic reset;

  logic       iniciar_v [4];
  logic       modo_v    [4];
  logic       pronto_v  [4];
  logic [7:0] dados_v   [4];
  logic       ler_v     [4];

  logic [15:0] pal0, pal1, pal3;
  logic [7:0]  pal2;
  logic [3:0]  qt0, qt1, qt2;
  logic [1:0]  qt3;

  logic [15:0] palavra_w [4];
  logic [3:0]  quant_w   [4];
  logic        valida_w  [4];
  logic        cheio_w   [4];
  logic [15:0] receb_w   [4];
  logic        fim_w     [4];
  logic        erro_w    [4];
  logic [1:0]  estado_w  [4];

  int checks = 0;
  int errors = 0;
  int fim_cnt [4] = '{0, 0, 0, 0};

  logic [15:0] sb [$];

  typedef struct {
    logic [7:0]  b_msb;
    logic [7:0]  b_lsb;
    logic [15:0] esperado;
  } vec_t;

  vec_t tabela [4];

  always_comb begin
    palavra_w[0] = pal0;
    palavra_w[1] = pal1;
    palavra_w[2] = {8'h00, pal2};
    palavra_w[3] = pal3;
    quant_w[0]   = qt0;
    quant_w[1]   = qt1;
    quant_w[2]   = qt2;
    quant_w[3]   = {2'b00, qt3};
  end

  rx_pacote_serial #(.TIMEOUT_CYCLES(100)) u_def (
    .clock(clock), .reset(reset), .iniciar(iniciar_v[0]), .modo(modo_v[0]),
    .rx_pronto(pronto_v[0]), .rx_dados(dados_v[0]), .ler(ler_v[0]),
    .palavra(pal0), .palavra_valida(valida_w[0]), .cheio(cheio_w[0]),
    .quantidade(qt0), .palavras_recebidas(receb_w[0]), .fim_quadro(fim_w[0]),
    .erro_overflow(erro_w[0]), .db_estado(estado_w[0]));

  rx_pacote_serial #(.FRAME_WORDS(4)) u_f4 (
    .clock(clock), .reset(reset), .iniciar(iniciar_v[1]), .modo(modo_v[1]),
    .rx_pronto(pronto_v[1]), .rx_dados(dados_v[1]), .ler(ler_v[1]),
    .palavra(pal1), .palavra_valida(valida_w[1]), .cheio(cheio_w[1]),
    .quantidade(qt1), .palavras_recebidas(receb_w[1]), .fim_quadro(fim_w[1]),
    .erro_overflow(erro_w[1]), .db_estado(estado_w[1]));

  rx_pacote_serial #(.WORD_BYTES(1)) u_w1 (
    .clock(clock), .reset(reset), .iniciar(iniciar_v[2]), .modo(modo_v[2]),
    .rx_pronto(pronto_v[2]), .rx_dados(dados_v[2]), .ler(ler_v[2]),
    .palavra(pal2), .palavra_valida(valida_w[2]), .cheio(cheio_w[2]),
    .quantidade(qt2), .palavras_recebidas(receb_w[2]), .fim_quadro(fim_w[2]),
    .erro_overflow(erro_w[2]), .db_estado(estado_w[2]));

  rx_pacote_serial #(.DEPTH(2)) u_d2 (
    .clock(clock), .reset(reset), .iniciar(iniciar_v[3]), .modo(modo_v[3]),
    .rx_pronto(pronto_v[3]), .rx_dados(dados_v[3]), .ler(ler_v[3]),
    .palavra(pal3), .palavra_valida(valida_w[3]), .cheio(cheio_w[3]),
    .quantidade(qt3), .palavras_recebidas(receb_w[3]), .fim_quadro(fim_w[3]),
    .erro_overflow(erro_w[3]), .db_estado(estado_w[3]));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (fim_w[i] === 1'b1) fim_cnt[i]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    @(negedge clock);
    pronto_v[k] = 1'b1;
    dados_v[k]  = b;
    @(negedge clock);
    pronto_v[k] = 1'b0;
  endtask

  task automatic start(input int k, input logic m);
    @(negedge clock);
    iniciar_v[k] = 1'b1;
    modo_v[k]    = m;
    @(negedge clock);
    iniciar_v[k] = 1'b0;
  endtask

  task automatic pop_check(input int k, input string nome);
    logic [15:0] exp;
    @(negedge clock);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h", nome, palavra_w[k]);
    end else begin
      exp = sb.pop_front();
      chk({nome, "_valida"}, {31'd0, valida_w[k]}, 32'd1);
      chk(nome, {16'd0, palavra_w[k]}, {16'd0, exp});
    end
    ler_v[k] = 1'b1;
    @(negedge clock);
    ler_v[k] = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string nome);
    chk({nome, "_palavra"}, {16'd0, palavra_w[k]}, 32'd0);
    chk({nome, "_valida"},  {31'd0, valida_w[k]},  32'd0);
    chk({nome, "_cheio"},   {31'd0, cheio_w[k]},   32'd0);
    chk({nome, "_quant"},   {28'd0, quant_w[k]},   32'd0);
    chk({nome, "_receb"},   {16'd0, receb_w[k]},   32'd0);
    chk({nome, "_fim"},     {31'd0, fim_w[k]},     32'd0);
    chk({nome, "_erro"},    {31'd0, erro_w[k]},    32'd0);
    chk({nome, "_estado"},  {30'd0, estado_w[k]},  32'd0);
  endtask

  initial begin
    tabela[0] = '{8'h10, 8'h0A, 16'h100A};
    tabela[1] = '{8'h68, 8'h00, 16'h6800};
    tabela[2] = '{8'h03, 8'hE5, 16'h03E5};
    tabela[3] = '{8'h5B, 8'h23, 16'h5B23};

    for (int i = 0; i < 4; i++) begin
      iniciar_v[i] = 1'b0; modo_v[i] = 1'b0; pronto_v[i] = 1'b0;
      dados_v[i] = 8'h00; ler_v[i] = 1'b0;
    end

    // Reset dominates simultaneous iniciar/rx_pronto.
    reset = 1'b1;
    iniciar_v[0] = 1'b1; pronto_v[0] = 1'b1; dados_v[0] = 8'h55;
    repeat (3) @(negedge clock);
    chk_zero(0, "reset");
    reset = 1'b0; iniciar_v[0] = 1'b0; pronto_v[0] = 1'b0;

    // Fixed-count frame, default geometry: four words, no completion.
    start(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(0, tabela[i].b_msb);
      send_byte(0, tabela[i].b_lsb);
      sb.push_back(tabela[i].esperado);
    end
    chk("t1_quant", {28'd0, quant_w[0]}, 32'd4);
    chk("t1_receb", {16'd0, receb_w[0]}, 32'd4);
    chk("t1_estado", {30'd0, estado_w[0]}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check(0, "t1_pop");
    chk("t1_vazio", {31'd0, valida_w[0]}, 32'd0);
    chk("t1_hold", {16'd0, palavra_w[0]}, 32'h5B23);
    chk("t1_sem_fim", fim_cnt[0], 32'd0);

    // Frame completion with FRAME_WORDS=4.
    sb.delete();
    start(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(1, tabela[i].b_msb);
      if (i == 3) chk("t2_fim_cedo", {31'd0, fim_w[1]}, 32'd0);
      send_byte(1, tabela[i].b_lsb);
      sb.push_back(tabela[i].esperado);
    end
    chk("t2_fim", {31'd0, fim_w[1]}, 32'd1);
    chk("t2_estado", {30'd0, estado_w[1]}, 32'd2);
    @(negedge clock);
    chk("t2_fim_pulso", {31'd0, fim_w[1]}, 32'd0);
    send_byte(1, 8'h10);
    @(negedge clock);
    chk("t2_ignora", {28'd0, quant_w[1]}, 32'd4);
    for (int i = 0; i < 4; i++) pop_check(1, "t2_pop");
    chk("t2_fim_cnt", fim_cnt[1], 32'd1);

    // Zero-terminated list with 1-byte words.
    sb.delete();
    start(2, 1'b1);
    send_byte(2, 8'h01); sb.push_back(16'h0001);
    send_byte(2, 8'h02); sb.push_back(16'h0002);
    send_byte(2, 8'h03); sb.push_back(16'h0003);
    send_byte(2, 8'h00);
    chk("t3_fim", {31'd0, fim_w[2]}, 32'd1);
    chk("t3_receb", {16'd0, receb_w[2]}, 32'd3);
    chk("t3_quant", {28'd0, quant_w[2]}, 32'd3);
    chk("t3_estado", {30'd0, estado_w[2]}, 32'd2);
    for (int i = 0; i < 3; i++) pop_check(2, "t3_pop");
    chk("t3_fim_cnt", fim_cnt[2], 32'd1);

    // Overflow with DEPTH=2; third word dropped but counted.
    sb.delete();
    start(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(3, tabela[i].b_msb);
      send_byte(3, tabela[i].b_lsb);
      if (i < 2) sb.push_back(tabela[i].esperado);
    end
    chk("t4_quant", {28'd0, quant_w[3]}, 32'd2);
    chk("t4_cheio", {31'd0, cheio_w[3]}, 32'd1);
    chk("t4_erro", {31'd0, erro_w[3]}, 32'd1);
    chk("t4_cabeca", {16'd0, palavra_w[3]}, 32'h100A);
    chk("t4_receb", {16'd0, receb_w[3]}, 32'd3);
    start(3, 1'b0);
    chk("t4_limpa_erro", {31'd0, erro_w[3]}, 32'd0);
    chk("t4_mantem", {28'd0, quant_w[3]}, 32'd2);

    // ler together with word completion while full.
    send_byte(3, 8'h5B);
    @(negedge clock);
    chk("b1_head", {16'd0, palavra_w[3]}, {16'd0, sb.pop_front()});
    pronto_v[3] = 1'b1; dados_v[3] = 8'h23; ler_v[3] = 1'b1;
    @(negedge clock);
    pronto_v[3] = 1'b0; ler_v[3] = 1'b0;
    sb.push_back(16'h5B23);
    chk("b1_quant", {28'd0, quant_w[3]}, 32'd2);
    chk("b1_erro", {31'd0, erro_w[3]}, 32'd0);
    pop_check(3, "b1_pop");
    pop_check(3, "b1_pop");

    // iniciar after one byte discards it.
    sb.delete();
    start(0, 1'b0);
    send_byte(0, 8'h11);
    start(0, 1'b0);
    send_byte(0, 8'h22);
    send_byte(0, 8'h33);
    sb.push_back(16'h2233);
    chk("b3_receb", {16'd0, receb_w[0]}, 32'd1);
    pop_check(0, "b3_pop");

`ifdef RX_TIMEOUT_EN
    // Stalled partial word is discarded after the timeout.
    sb.delete();
    start(0, 1'b0);
    send_byte(0, 8'hAA);
    repeat (150) @(negedge clock);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    sb.push_back(16'h1234);
    chk("to_quant", {28'd0, quant_w[0]}, 32'd1);
    pop_check(0, "to_pop");
`endif

    // Reset in the middle of a word clears everything; next word is fresh.
    sb.delete();
    start(0, 1'b0);
    send_byte(0, 8'h55);
    send_byte(0, 8'h66);
    send_byte(0, 8'hAB);
    chk("b2_pre_quant", {28'd0, quant_w[0]}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_zero(0, "b2_reset");
    start(0, 1'b0);
    send_byte(0, 8'h77);
    send_byte(0, 8'h88);
    sb.push_back(16'h7788);
    pop_check(0, "b2_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_pacote_serial.md
Name: rx_pacote_serial

Overview:
- Packs the byte stream from rx_serial_8N1 (pronto/dados_ascii) into WORD_BYTES-wide words and buffers them in a DEPTH-entry show-ahead FIFO for the robot control unit.
- Two frame modes:
  - Fixed-count frame: e.g. sticker colour words, 16-bit, MSB byte first.
  - Zero-terminated list: e.g. move codes ended by a null word.
- Successor to the fixed 2-byte colour capture; generalised in word width, depth, frame length and mode, with overflow detection.

Parameters:
- WORD_BYTES, 2, bytes per word; first received byte lands in the most-significant byte.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- FRAME_WORDS, 16, words per frame in fixed-count mode.
- TIMEOUT_CYCLES, 5000000, inter-byte timeout in clocks; used only with RX_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  one-cycle pulse; arms a new frame.
- modo  in  1  0 = fixed-count frame, 1 = zero-terminated list; sampled on iniciar.
- rx_pronto  in  1  one-cycle pulse; rx_dados valid.
- rx_dados  in  8  received byte.
- ler  in  1  pop head word.
- palavra  out  8*WORD_BYTES  FIFO head word.
- palavra_valida  out  1  FIFO not empty.
- cheio  out  1  FIFO full.
- quantidade  out  $clog2(DEPTH)+1  FIFO occupancy.
- palavras_recebidas  out  16  words accepted this frame; excludes the terminator.
- fim_quadro  out  1  one-cycle pulse when the frame completes.
- erro_overflow  out  1  sticky overflow flag.
- db_estado  out  2  FSM state code.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - FSM to OCIOSO; FIFO emptied; byte index 0; partial-word register 0.
  - All outputs 0: palavra=0, palavra_valida=0, cheio=0, quantidade=0, palavras_recebidas=0, fim_quadro=0, erro_overflow=0, db_estado=0.
  - Reset overrides every other input in the same cycle.
- FSM states: OCIOSO=0, RECEBE=1, FIM=2.
  - OCIOSO --iniciar--> RECEBE.
  - RECEBE --frame complete--> FIM.
  - FIM --iniciar--> RECEBE.
  - iniciar in RECEBE restarts the frame.
- On every iniciar:
  - Latch modo.
  - Clear byte index, partial word, palavras_recebidas and erro_overflow.
  - FIFO contents are kept; the consumer drains them.
- Byte handling:
  - rx_pronto is ignored outside RECEBE, and in the same cycle as iniciar.
  - In RECEBE, each rx_pronto shifts rx_dados into the partial word (shift left 8) and increments the byte index.
  - When the index reaches WORD_BYTES, the word completes and the index wraps to 0.
- Word completion, modo=0:
  - Push the word and increment palavras_recebidas.
  - When the count reaches FRAME_WORDS: fim_quadro pulses, FSM goes to FIM.
- Word completion, modo=1:
  - Word == 0: terminator. Not pushed; fim_quadro pulses; FSM goes to FIM.
  - Otherwise: push and increment palavras_recebidas (saturates at 16'hFFFF).
- Timing:
  - A pushed word is visible on palavra/palavra_valida on the cycle after the completing rx_pronto edge.
  - fim_quadro is asserted on that same cycle.
- FIFO:
  - Show-ahead: palavra = head when not empty; holds the last value when empty.
  - ler when empty is ignored.
  - Push and pop in the same cycle with FIFO full: both succeed, occupancy unchanged.
  - Push and pop in the same cycle with FIFO empty: the word is stored and the pop is ignored.
- Overflow:
  - A push while full, without a simultaneous ler, drops the word.
  - erro_overflow is set and held until the next iniciar or reset.
  - The dropped word still counts toward palavras_recebidas and toward frame completion.
- Pointers wrap modulo DEPTH; quantidade ranges 0..DEPTH.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - A counter runs in RECEBE while the byte index is nonzero and clears on each rx_pronto.
  - When it reaches TIMEOUT_CYCLES, the partial word is discarded and the byte index returns to 0.
  - Frame state, FIFO and the error flag are unaffected.
- Undefined:
  - No counter; a partial word waits indefinitely.

Decomposition:
- Shared package rubiks_pkg holds:
  - State encodings OCIOSO/RECEBE/FIM.
  - Byte constants BYTE_SINCRONISMO=8'hFF and BYTE_NULO=8'h00.
  - Default WORD_BYTES/DEPTH/FRAME_WORDS.
- One sub-module: fifo_sincrona, parameterised by width and depth, show-ahead, with cheio/vazio/quantidade outputs.
- Byte packing and the FSM stay in the top level.

Test Plan:
- Fixed-count frame with default parameters: reset, iniciar with modo=0, 8 bytes 10 0A 68 00 03 E5 5B 23.
  - FIFO holds 16'h100A, 16'h6800, 16'h03E5, 16'h5B23; quantidade=4.
  - Popping returns them in order; no fim_quadro.
- Frame completion: FRAME_WORDS=4, same 8 bytes.
  - fim_quadro pulses one cycle after byte 23; db_estado=2.
  - A further byte 10 is ignored; quantidade stays 4.
- Zero-terminated list: WORD_BYTES=1, modo=1, bytes 01 02 03 00.
  - FIFO holds 01, 02, 03; palavras_recebidas=3; fim_quadro pulses once.
- Overflow: DEPTH=2, modo=0, 6 bytes with no ler.
  - quantidade=2, cheio=1, erro_overflow=1; the head is still 16'h100A.
  - iniciar clears erro_overflow.
- Boundaries:
  - ler and word completion in the same cycle while full: quantidade unchanged, no error.
  - Reset asserted after 1 byte of a 2-byte word: all outputs 0.
  - iniciar after 1 byte: the next 2 bytes form a fresh word.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte AA, wait 150 cycles, then bytes 12 34.
  - FIFO holds 16'h1234 only.
